// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame, ACK sample, result report.
// Optional PS2_HOST_TX_RETRY_EN: a NAK or timeout retries the same byte up to twice before tx_done.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);
    // state     | meaning
    // IDLE      | lines released, waiting for tx_start
    // INHIBIT   | clock held low
    // RTS       | clock and data (start bit) held low
    // SEND      | frame bit placed on each device clock fall
    // ACK       | device ACK/NAK sampled on next fall
    // WAIT_IDLE | waiting for both lines high
    // DONE      | one-cycle result pulse
    localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(MAX_C + 1);
    localparam int FW    = $clog2(FILTER_LEN + 1);

    localparam logic [TW-1:0] INH_LOAD  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] RTS_LOAD  = TW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE
    } state_t;

    logic          c_meta, c_sync, d_meta, d_sync;
    logic          c_filt, c_filt_q;
    logic [FW-1:0] fcnt;
    logic          fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_meta   <= 1'b1;
            c_sync   <= 1'b1;
            d_meta   <= 1'b1;
            d_sync   <= 1'b1;
            c_filt   <= 1'b1;
            c_filt_q <= 1'b1;
            fcnt     <= '0;
        end else begin
            c_meta   <= ps2c_in;
            c_sync   <= c_meta;
            d_meta   <= ps2d_in;
            d_sync   <= d_meta;
            c_filt_q <= c_filt;
            if (c_sync == c_filt) begin
                fcnt <= '0;
            end else if (fcnt == FILT_LAST) begin
                c_filt <= c_sync;
                fcnt   <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign fall = c_filt_q & ~c_filt;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    idx, idx_n;
    logic [8:0]    frame, frame_n;
    logic          res_ack, res_ack_n, res_err, res_err_n;
    logic          d_low_n, timeout;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]    retry, retry_n;
`endif

    always_comb begin
        state_n   = state;
        timer_n   = (timer == '0) ? timer : timer - TW'(1);
        idx_n     = idx;
        frame_n   = frame;
        res_ack_n = res_ack;
        res_err_n = res_err;
        d_low_n   = ps2d_drive_low;
        timeout   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_n   = retry;
`endif
        case (state)
            S_IDLE: begin
                d_low_n = 1'b0;
                if (tx_start) begin
                    frame_n   = {~^tx_data, tx_data};
                    timer_n   = INH_LOAD;
                    res_ack_n = 1'b0;
                    res_err_n = 1'b0;
                    state_n   = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_n   = 2'd0;
`endif
                end
            end
            S_INHIBIT: if (timer == '0) begin
                timer_n = RTS_LOAD;
                d_low_n = 1'b1;
                state_n = S_RTS;
            end
            S_RTS: if (timer == '0) begin
                timer_n = TO_LOAD;
                idx_n   = '0;
                state_n = S_SEND;
            end
            S_SEND: begin
                if (fall) begin
                    // idx 9 is the stop bit: the data line is simply released
                    d_low_n = (idx == 4'd9) ? 1'b0 : ~frame[idx];
                    idx_n   = idx + 4'd1;
                    timer_n = TO_LOAD;
                    if (idx == 4'd9) state_n = S_ACK;
                end else if (timer == '0) begin
                    timeout = 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    res_ack_n = ~d_sync;
                    res_err_n = d_sync;
                    d_low_n   = 1'b0;
                    timer_n   = TO_LOAD;
                    state_n   = S_WAIT_IDLE;
                end else if (timer == '0) begin
                    timeout = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (c_sync && d_sync) state_n = S_DONE;
                else if (timer == '0) timeout = 1'b1;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (timeout) begin
            d_low_n   = 1'b0;
            res_ack_n = 1'b0;
            res_err_n = 1'b1;
            state_n   = S_DONE;
        end
`ifdef PS2_HOST_TX_RETRY_EN
        // a failed attempt with retries left restarts instead of reporting
        if (state_n == S_DONE && res_err_n && retry != 2'd2) begin
            state_n   = S_INHIBIT;
            timer_n   = INH_LOAD;
            retry_n   = retry + 2'd1;
            res_ack_n = 1'b0;
            res_err_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            timer          <= '0;
            idx            <= '0;
            frame          <= '0;
            res_ack        <= 1'b0;
            res_err        <= 1'b0;
            ps2c_drive_low <= 1'b0;
            ps2d_drive_low <= 1'b0;
            tx_busy        <= 1'b0;
            tx_done        <= 1'b0;
            tx_ack_ok      <= 1'b0;
            tx_error       <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry          <= 2'd0;
`endif
        end else begin
            state          <= state_n;
            timer          <= timer_n;
            idx            <= idx_n;
            frame          <= frame_n;
            res_ack        <= res_ack_n;
            res_err        <= res_err_n;
            ps2c_drive_low <= (state_n == S_INHIBIT) || (state_n == S_RTS);
            ps2d_drive_low <= d_low_n;
            tx_busy        <= (state_n != S_IDLE);
            tx_done        <= (state_n == S_DONE);
            if (state_n == S_DONE) begin
                tx_ack_ok <= res_ack_n;
                tx_error  <= res_err_n;
            end
`ifdef PS2_HOST_TX_RETRY_EN
            retry          <= retry_n;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on the resolved open-drain lines, frame model from the byte.
module tb_ps2_host_tx;
    localparam int INH = 1000;
    localparam int RTS = 100;
    localparam int TO  = 3000;
    localparam int FL  = 8;
    localparam int H   = 25;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_c_low = 1'b0, dev_d_low = 1'b0;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_ack_ok, tx_error;

    int n_cmp = 0, n_err = 0, cyc = 0, done_cnt = 0, last_done_cyc = 0;
    logic last_ack = 1'b0, last_err = 1'b0;

    assign ps2c_in = ~(ps2c_drive_low | dev_c_low);
    assign ps2d_in = ~(ps2d_drive_low | dev_d_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk(clk), .reset(reset), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_drive_low(ps2c_drive_low), .ps2d_drive_low(ps2d_drive_low),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_ack_ok(tx_ack_ok), .tx_error(tx_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (tx_done) begin
        done_cnt++;
        last_ack = tx_ack_ok;
        last_err = tx_error;
        last_done_cyc = cyc;
    end

    initial begin
        #1000000;
        $display("FAIL bench_time_limit reached at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic start(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device side: measure inhibit/RTS, clock out nbits, optionally ACK/NAK after the stop bit.
    task automatic device_xfer(input bit nak, input int nbits, input int glitch_at,
                               output logic [9:0] got, output int inh_len, output int rts_len,
                               output logic start_lvl, output int fall_cyc);
        got = '0; inh_len = 0; rts_len = 0; fall_cyc = 0;
        for (int i = 0; i < INH + TO + 500 && !ps2c_drive_low; i++) @(negedge clk);
        while (ps2c_drive_low && !ps2d_drive_low && inh_len < 4 * INH) begin inh_len++; @(negedge clk); end
        while (ps2c_drive_low && ps2d_drive_low && rts_len < 4 * RTS) begin rts_len++; @(negedge clk); end
        repeat (30) @(negedge clk);
        start_lvl = ps2d_in;
        for (int i = 0; i < nbits; i++) begin
            dev_c_low = 1'b1;
            fall_cyc = cyc;
            repeat (H) @(negedge clk);
            got[i] = ps2d_in;
            dev_c_low = 1'b0;
            if (i == glitch_at) begin
                repeat (8) @(negedge clk);
                dev_c_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (H - 11) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        if (nbits == 10) begin
            dev_d_low = ~nak;
            repeat (5) @(negedge clk);
            dev_c_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_d_low = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (ps2c_drive_low !== 1'b0) begin n_err++; $display("FAIL reset_c_low got %b want 0", ps2c_drive_low); end
        n_cmp++; if (ps2d_drive_low !== 1'b0) begin n_err++; $display("FAIL reset_d_low got %b want 0", ps2d_drive_low); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", tx_done); end
        n_cmp++; if ({tx_ack_ok, tx_error} !== 2'b00) begin n_err++; $display("FAIL reset_result got %b want 00", {tx_ack_ok, tx_error}); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] b, input bit nak, input string name);
        logic [9:0] got; int inh, rts, fc, d0; logic sl;
        d0 = done_cnt;
        start(b);
        for (int a = 0; a < (nak ? ATTEMPTS : 1); a++) device_xfer(nak, 10, -1, got, inh, rts, sl, fc);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (inh !== INH) begin n_err++; $display("FAIL %s inhibit_len got %0d want %0d", name, inh, INH); end
        n_cmp++; if (rts !== RTS) begin n_err++; $display("FAIL %s rts_len got %0d want %0d", name, rts, RTS); end
        n_cmp++; if (sl !== 1'b0) begin n_err++; $display("FAIL %s start_bit got %b want 0", name, sl); end
        n_cmp++; if (got !== exp_frame(b)) begin n_err++; $display("FAIL %s frame got %b want %b", name, got, exp_frame(b)); end
        n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL %s done_count got %0d want %0d", name, done_cnt - d0, 1); end
        n_cmp++; if ({last_ack, last_err} !== {~nak, nak}) begin n_err++; $display("FAIL %s ack_err got %b want %b", name, {last_ack, last_err}, {~nak, nak}); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({ps2c_drive_low, ps2d_drive_low, tx_busy} !== 3'b000) begin n_err++; $display("FAIL %s idle_lines got %b want 000", name, {ps2c_drive_low, ps2d_drive_low, tx_busy}); end
    endtask

    task automatic test_parity();
        test_frame(8'h00, 1'b0, "parity_00");
        test_frame(8'h01, 1'b0, "parity_01");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) test_frame(8'($urandom_range(0, 255)), 1'b0, "random");
    endtask

    task automatic test_timeout();
        logic [9:0] got; int inh, rts, fc, d0, dt; logic sl;
        d0 = done_cnt;
        start(8'($urandom_range(0, 255)));
        for (int a = 0; a < ATTEMPTS; a++) device_xfer(1'b0, 4, -1, got, inh, rts, sl, fc);
        for (int i = 0; i < TO + 300 && done_cnt == d0; i++) @(posedge clk);
        @(negedge clk);
        dt = last_done_cyc - fc;
        n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL timeout_done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if ({last_ack, last_err} !== 2'b01) begin n_err++; $display("FAIL timeout_ack_err got %b want 01", {last_ack, last_err}); end
        n_cmp++; if (dt < TO || dt > TO + FL + 8) begin n_err++; $display("FAIL timeout_delay got %0d want %0d..%0d", dt, TO, TO + FL + 8); end
        n_cmp++; if ({ps2c_drive_low, ps2d_drive_low} !== 2'b00) begin n_err++; $display("FAIL timeout_lines got %b want 00", {ps2c_drive_low, ps2d_drive_low}); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch();
        logic [9:0] got; int inh, rts, fc, d0; logic sl; logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        start(b);
        device_xfer(1'b0, 10, 3, got, inh, rts, sl, fc);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (got !== exp_frame(b)) begin n_err++; $display("FAIL glitch_frame got %b want %b", got, exp_frame(b)); end
        n_cmp++; if ({last_ack, last_err} !== 2'b10) begin n_err++; $display("FAIL glitch_ack_err got %b want 10", {last_ack, last_err}); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [9:0] got; int inh, rts, fc, d0; logic sl; logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        start(b);
        repeat (20) @(negedge clk);
        start(~b);
        device_xfer(1'b0, 10, -1, got, inh, rts, sl, fc);
        for (int i = 0; i < 300 && !tx_done; i++) @(negedge clk);
        tx_data = ~b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (got !== exp_frame(b)) begin n_err++; $display("FAIL busy_ignore_frame got %b want %b", got, exp_frame(b)); end
        n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL busy_ignore_done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if ({tx_busy, ps2c_drive_low} !== 2'b00) begin n_err++; $display("FAIL start_on_done got %b want 00", {tx_busy, ps2c_drive_low}); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] got; int inh, rts, fc, d0; logic sl;
        d0 = done_cnt;
        start(8'hA5);
        device_xfer(1'b0, 4, -1, got, inh, rts, sl, fc);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done} !== 4'b0000) begin n_err++; $display("FAIL reset_mid_outputs got %b want 0000", {ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done}); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL reset_mid_no_done got %0d want 0", done_cnt - d0); end
    endtask

`ifdef PS2_HOST_TX_RETRY_EN
    task automatic test_retry();
        logic [9:0] got; int inh, rts, fc, d0; logic sl; logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        start(b);
        device_xfer(1'b1, 10, -1, got, inh, rts, sl, fc);
        device_xfer(1'b1, 10, -1, got, inh, rts, sl, fc);
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL retry_early_done got %0d want 0", done_cnt - d0); end
        device_xfer(1'b0, 10, -1, got, inh, rts, sl, fc);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (got !== exp_frame(b)) begin n_err++; $display("FAIL retry_frame got %b want %b", got, exp_frame(b)); end
        n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL retry_done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if ({last_ack, last_err} !== 2'b10) begin n_err++; $display("FAIL retry_ack_err got %b want 10", {last_ack, last_err}); end
        repeat (10) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_frame(8'hED, 1'b0, "cmd_ED");
        test_parity();
        test_random();
        test_frame(8'($urandom_range(0, 255)), 1'b1, "nak");
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
`ifdef PS2_HOST_TX_RETRY_EN
        test_retry();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
